tm1637_driver: RTL
==================

Name: tm1637_driver

Overview:
Downstream consumer of the timer's four 7-segment bytes. It drives a TM1637 4-digit LED controller over its two-wire CLK/DIO serial bus. DIO is open-drain. The block refreshes the display continuously, latching a fresh snapshot of the segment bytes at the start of every frame. It sits between the timer and the board pins.

Parameters:
TICK_DIV, 125, system clocks per bus tick (≥2); each FSM bus action occupies one tick
REFRESH_GAP, 2000, idle ticks between frames and after reset before the first frame

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous reset, active-low
data_one  in  8  segment byte, rightmost digit (grid 3); bit7 = DP/colon
data_two  in  8  segment byte, grid 2
data_three  in  8  segment byte, grid 1
data_four  in  8  segment byte, leftmost digit (grid 0)
brightness  in  3  TM1637 pulse-width setting 0..7
display_on  in  1  1 = display enabled
tm_dio_in  in  1  sampled DIO pin level (ACK input)
tm_clk  out  1  TM1637 CLK, push-pull
tm_dio_oe  out  1  1 = drive DIO low, 0 = release (pulled high externally)
busy  out  1  high from first START tick to end of final STOP
frame_done  out  1  one-clock pulse when the final STOP completes
ack_err  out  1  sticky: set if any ACK is sampled high

Behaviour:
- Reset values: tm_clk=1, tm_dio_oe=0, busy=0, frame_done=0, ack_err=0. Tick counter=0. FSM=GAP with REFRESH_GAP ticks loaded.
- Tick generation: the tick counter runs 0..TICK_DIV-1. The tick strobe fires when the counter = TICK_DIV-1. FSM outputs change only on tick strobes.
- Frame latch: on the tick that leaves GAP, capture data_one..four, brightness and display_on into shadow registers. Input changes during the frame have no effect until the next frame.
- Frame content, sent as three transactions back to back:
  - T1: START, 0x40, STOP.
  - T2: START, 0xC0, data_four, data_three, data_two, data_one, STOP.
  - T3: START, cmd3, STOP, where cmd3 = display_on ? (0x88 | brightness) : 0x80.
- Bits are sent LSB first.
- START (2 ticks), entered with CLK=1 and DIO released: t0 oe=1; t1 clk=0.
- Data bit (3 ticks each): t0 clk=0; t1 oe=~bit; t2 clk=1.
- ACK (4 ticks): t0 clk=0; t1 oe=0; t2 clk=1; t3 sample tm_dio_in, set ack_err if it reads 1.
- STOP (4 ticks): t0 clk=0; t1 oe=1; t2 clk=1; t3 oe=0.
- Tick counts: byte = 28 ticks; T1 = 34; T2 = 146; T3 = 34; frame = 214 ticks, then REFRESH_GAP ticks idle.
- FSM states: GAP, START, BIT, ACK, STOP. The byte index (0..7 within a frame) selects the transaction and the byte source.
- busy goes 1 on START t0 of T1 and returns 0 on STOP t3 of T3. frame_done pulses for one clock on the T3 STOP t3 tick. The FSM then returns to GAP.
- An ACK error does not abort the frame. The transfer continues, and ack_err stays set until reset.
- Reset mid-frame: on the next clock edge all outputs return to reset values, releasing the bus with CLK high. The TM1637 resynchronises on the next START.

Test Plan:
- TICK_DIV=4, REFRESH_GAP=10, model ACKs low; data_four..one = 0x3F,0x06,0x5B,0x4F; brightness=7, display_on=1 -> bus decoder sees 0x40 | 0xC0,3F,06,5B,4F | 0x8F; frame_done pulses once at 214 ticks (856 clocks) after busy rises; ack_err=0.
- Change data_one from 0x4F to 0x66 mid-T2 -> current frame still sends 0x4F; next frame sends 0x66.
- display_on=0, brightness=3 -> T3 byte = 0x80; display_on=1 -> 0x8B.
- Model holds DIO high on the 2nd ACK of T2 -> ack_err rises at that ACK t3 and stays 1 through later frames; frame completes normally.
- Assert reset_n low during T2 bit 4 -> next clock: tm_clk=1, tm_dio_oe=0, busy=0; after release, a fresh full frame follows REFRESH_GAP ticks.
- Protocol checker on every frame: DIO changes only while CLK=0 except in START/STOP; gap between frame_done and next busy = 10 ticks.

Source files
------------

// File: rtl/tm1637_driver_if.sv
// TM1637 two-wire bus: push-pull CLK, open-drain DIO enable and the sampled DIO pin.
interface tm1637_driver_if;
   logic tm_clk;
   logic tm_dio_oe;
   logic tm_dio_in;

   modport master (
      output tm_clk,
      output tm_dio_oe,
      input  tm_dio_in
   );

   modport slave (
      input  tm_clk,
      input  tm_dio_oe,
      output tm_dio_in
   );
endinterface

// File: rtl/tm1637_driver.sv
// Continuously refreshes a TM1637 4-digit display from four segment bytes.
// Each frame: data command, address + four digits, display control, then an idle gap.
module tm1637_driver #(
   parameter int unsigned TICK_DIV    = 125,
   parameter int unsigned REFRESH_GAP = 2000
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [7:0]      data_one,
   input  logic [7:0]      data_two,
   input  logic [7:0]      data_three,
   input  logic [7:0]      data_four,
   input  logic [2:0]      brightness,
   input  logic            display_on,
   tm1637_driver_if.master bus,
   output logic            busy,
   output logic            frame_done,
   output logic            ack_err
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned GapW = $clog2(REFRESH_GAP + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(TICK_DIV - 1);
   localparam logic [GapW-1:0] GapLoad = GapW'(REFRESH_GAP);

   typedef enum logic [2:0] {StGap, StStart, StBit, StAck, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic [1:0]      ph_q, ph_d;
   logic [2:0]      bit_q, bit_d;
   logic [2:0]      byte_q, byte_d;
   logic [7:0]      sh_one_q, sh_two_q, sh_three_q, sh_four_q;
   logic [2:0]      sh_bright_q;
   logic            sh_on_q;
   logic            clk_q, clk_d;
   logic            oe_q, oe_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            tick;
   logic            latch;
   logic            txn_end;
   logic [7:0]      cur_byte;

   assign tick    = (cnt_q == CntMax);
   assign cnt_d   = tick ? '0 : cnt_q + CntW'(1);
   // Bytes 0, 5 and 6 close the three transactions of a frame.
   assign txn_end = (byte_q == 3'd0) || (byte_q == 3'd5) || (byte_q == 3'd6);

   always_comb begin
      cur_byte = sh_on_q ? {5'b10001, sh_bright_q} : 8'h80;
      case (byte_q)
         3'd0:    cur_byte = 8'h40;
         3'd1:    cur_byte = 8'hC0;
         3'd2:    cur_byte = sh_four_q;
         3'd3:    cur_byte = sh_three_q;
         3'd4:    cur_byte = sh_two_q;
         3'd5:    cur_byte = sh_one_q;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      clk_d   = clk_q;
      oe_d    = oe_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      latch   = 1'b0;
      if (tick) begin
         unique case (state_q)
            StGap: begin
               if (gap_q <= GapW'(1)) begin
                  latch   = 1'b1;
                  state_d = StStart;
                  ph_d    = 2'd0;
                  byte_d  = 3'd0;
               end else begin
                  gap_d = gap_q - GapW'(1);
               end
            end
            StStart: begin
               if (ph_q == 2'd0) begin
                  oe_d = 1'b1;
                  if (byte_q == 3'd0) busy_d = 1'b1;
                  ph_d = 2'd1;
               end else begin
                  clk_d   = 1'b0;
                  state_d = StBit;
                  ph_d    = 2'd0;
                  bit_d   = 3'd0;
               end
            end
            StBit: begin
               case (ph_q)
                  2'd0: begin clk_d = 1'b0; ph_d = 2'd1; end
                  2'd1: begin oe_d = ~cur_byte[bit_q]; ph_d = 2'd2; end
                  default: begin
                     clk_d = 1'b1;
                     ph_d  = 2'd0;
                     if (bit_q == 3'd7) state_d = StAck;
                     else               bit_d   = bit_q + 3'd1;
                  end
               endcase
            end
            StAck: begin
               ph_d = ph_q + 2'd1;
               case (ph_q)
                  2'd0: clk_d = 1'b0;
                  2'd1: oe_d  = 1'b0;
                  2'd2: clk_d = 1'b1;
                  default: begin
                     err_d = err_q | bus.tm_dio_in;
                     if (txn_end) begin
                        state_d = StStop;
                     end else begin
                        state_d = StBit;
                        bit_d   = 3'd0;
                        byte_d  = byte_q + 3'd1;
                     end
                  end
               endcase
            end
            StStop: begin
               ph_d = ph_q + 2'd1;
               case (ph_q)
                  2'd0: clk_d = 1'b0;
                  2'd1: oe_d  = 1'b1;
                  2'd2: clk_d = 1'b1;
                  default: begin
                     oe_d = 1'b0;
                     if (byte_q == 3'd6) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StGap;
                        gap_d   = GapLoad;
                     end else begin
                        state_d = StStart;
                        byte_d  = byte_q + 3'd1;
                     end
                  end
               endcase
            end
            default: state_d = StGap;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= StGap;
         cnt_q       <= '0;
         gap_q       <= GapLoad;
         ph_q        <= 2'd0;
         bit_q       <= 3'd0;
         byte_q      <= 3'd0;
         clk_q       <= 1'b1;
         oe_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         sh_one_q    <= 8'h00;
         sh_two_q    <= 8'h00;
         sh_three_q  <= 8'h00;
         sh_four_q   <= 8'h00;
         sh_bright_q <= 3'd0;
         sh_on_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         clk_q   <= clk_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (latch) begin
            sh_one_q    <= data_one;
            sh_two_q    <= data_two;
            sh_three_q  <= data_three;
            sh_four_q   <= data_four;
            sh_bright_q <= brightness;
            sh_on_q     <= display_on;
         end
      end
   end

   assign bus.tm_clk    = clk_q;
   assign bus.tm_dio_oe = oe_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;
   assign ack_err       = err_q;

endmodule
